pattern_edit_ctrl: RTL

Downstream consumer of the keycode mapper's edit and cursor outputs. Converts each new edit command (increment, decrement, delete) at the current cursor cell into one read-modify-write transaction on the single-port synchronous pattern RAM. Also reports the last cell value touched, for the display path.

---
 rtl/tracker_pkg.sv | 26 ++
 rtl/pattern_addr_calc.sv | 34 +++
 rtl/pattern_edit_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tracker_pkg.sv
// Shared pattern-editor types and geometry, used by the edit controller,
// the keycode mapper and the display reader.
package tracker_pkg;

  localparam int PAT_COLS   = 80;
  localparam int PAT_ROWS   = 30;
  localparam int PAT_ADDR_W = 12;
  localparam int PAT_DATA_W = 8;
  localparam int CURSOR_W   = 7;

  // Encoding matches the mapper's 2-bit edit level.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_DEL  = 2'b11
  } edit_op_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_WT   = 2'd2;
  localparam state_t ST_WR   = 2'd3;

endpackage

// File: rtl/pattern_addr_calc.sv
// Combinational cursor (x, y) to linear pattern RAM address, plus an in-range flag.
// The address is only meaningful when in_range_o is high.
module pattern_addr_calc
  import tracker_pkg::*;
#(
  parameter int COLS   = PAT_COLS,
  parameter int ROWS   = PAT_ROWS,
  parameter int ADDR_W = PAT_ADDR_W,
  parameter int CW     = CURSOR_W
) (
  input  logic [CW-1:0]     x_i,
  input  logic [CW-1:0]     y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_range_o
);

  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;

  assign x_ext = ADDR_W'(x_i);
  assign y_ext = ADDR_W'(y_i);

  generate
    if (COLS == 80) begin : g_shift_add
      // 80 = 64 + 16, so two shifts and an add replace the multiplier.
      assign addr_o = (y_ext << 6) + (y_ext << 4) + x_ext;
    end else begin : g_mul
      assign addr_o = ADDR_W'(y_ext * ADDR_W'(COLS)) + x_ext;
    end
  endgenerate

  assign in_range_o = (int'(x_i) < COLS) && (int'(y_i) < ROWS);

endmodule

// File: rtl/pattern_edit_ctrl.sv
// Turns each new edit command at the cursor into one read-modify-write on the
// single-port pattern RAM; commands arriving while a transaction runs are dropped.
module pattern_edit_ctrl
  import tracker_pkg::*;
#(
  parameter int                COLS      = PAT_COLS,
  parameter int                ROWS      = PAT_ROWS,
  parameter int                DATA_W    = PAT_DATA_W,
  parameter logic [DATA_W-1:0] MAX_VAL   = 8'hFF,
  parameter logic [DATA_W-1:0] EMPTY_VAL = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            user_edit_i,
  input  logic [CURSOR_W-1:0]   cursor_x_i,
  input  logic [CURSOR_W-1:0]   cursor_y_i,
  output logic [PAT_ADDR_W-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  output logic                  mem_we_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_W-1:0]     cell_value_o
);

  state_t                  state_q, state_d;
  edit_op_t                op_q, op_d;
  logic [1:0]              prev_edit_q;
  logic [PAT_ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       cell_q, cell_d;
  logic                    busy_q, rd_q, we_q, done_q, err_q;
  logic                    err_d;

  edit_op_t                cmd_op;
  logic                    new_cmd;
  logic [PAT_ADDR_W-1:0]   calc_addr;
  logic                    calc_in_range;
  logic [DATA_W-1:0]       edit_result;

  pattern_addr_calc #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (PAT_ADDR_W),
    .CW     (CURSOR_W)
  ) u_addr_calc (
    .x_i        (cursor_x_i),
    .y_i        (cursor_y_i),
    .addr_o     (calc_addr),
    .in_range_o (calc_in_range)
  );

  assign cmd_op  = edit_op_t'(user_edit_i);
  // Level-to-edge: a held key, or a key seen mid-transaction, never re-fires.
  assign new_cmd = (user_edit_i != 2'b00) && (user_edit_i != prev_edit_q);

  // Saturating update of the value read back from the RAM.
  always_comb begin
    edit_result = mem_rdata_i;
    case (op_q)
      OP_INC: begin
        if (mem_rdata_i < MAX_VAL) edit_result = mem_rdata_i + DATA_W'(1);
        else                       edit_result = MAX_VAL;
      end
      OP_DEC: begin
        if (mem_rdata_i != '0) edit_result = mem_rdata_i - DATA_W'(1);
        else                   edit_result = '0;
      end
      OP_DEL:  edit_result = EMPTY_VAL;
      default: edit_result = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cell_d  = cell_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (new_cmd) begin
          if (!calc_in_range) begin
            err_d = 1'b1;
          end else begin
            op_d   = cmd_op;
            addr_d = calc_addr;
            if (cmd_op == OP_DEL) begin
              state_d = ST_WR;
              wdata_d = EMPTY_VAL;
              cell_d  = EMPTY_VAL;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: state_d = ST_WT;
      ST_WT: begin
        state_d = ST_WR;
        wdata_d = edit_result;
        cell_d  = edit_result;
      end
      ST_WR:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output comes from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      prev_edit_q <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      cell_q      <= '0;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      prev_edit_q <= user_edit_i;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cell_q      <= cell_d;
      busy_q      <= (state_d != ST_IDLE);
      rd_q        <= (state_d == ST_RD);
      we_q        <= (state_d == ST_WR);
      done_q      <= (state_d == ST_WR);
      err_q       <= err_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_rd_o     = rd_q;
  assign mem_we_o     = we_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cell_value_o = cell_q;

endmodule
